// File: rtl/pipe_reg_hs.sv
// -----------------------------------------------------------------------------
// pipe_reg_hs
//   Pipeline register with a valid/ready handshake and a two-entry skid buffer.
//   One entry lives in the main register (drives o_out_data); a second entry can
//   be parked in the skid register when downstream stalls while upstream still
//   fires. This keeps o_in_ready a pure register output and still sustains one
//   transfer per cycle. A synchronous flush discards every held entry.
//
//   Optional feature macro: PIPE_REG_HS_STATS_EN
//     When defined, o_stall_cnt counts cycles with o_out_valid=1 and
//     i_out_ready=0, saturating at 2^CNT_W-1. Only i_rst clears it.
//
// Parameters
//   WIDTH      payload width in bits
//   RESET_VAL  o_out_data value after reset
//   CNT_W      width of o_stall_cnt
//
// Ports
//   i_clk        sole clock, rising edge
//   i_rst        synchronous active-high reset
//   i_flush      synchronous discard of all held entries
//   i_in_valid   upstream payload valid
//   o_in_ready   block can accept (registered)
//   i_in_data    upstream payload
//   o_out_valid  o_out_data holds a valid entry
//   i_out_ready  downstream accepts
//   o_out_data   head entry payload
//   o_stall_cnt  backpressure cycle count (PIPE_REG_HS_STATS_EN only)
// -----------------------------------------------------------------------------
module pipe_reg_hs #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
`ifdef PIPE_REG_HS_STATS_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt
`endif
);

  // state   | meaning
  // EMPTY   | no valid entry, skid empty
  // BUSY    | main valid, skid empty
  // FULL    | main and skid valid, o_in_ready low
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_out_valid;
  logic w_load_main;
  logic w_main_from_skid;
  logic w_load_skid;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = i_in_valid & r_in_ready;
  assign w_out_fire  = w_out_valid & i_out_ready;

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = w_out_valid;
  assign o_out_data  = r_main;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_load_main = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main = 1'b1;
        end else if (w_in_fire) begin
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_fire) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // o_in_ready is low here, so only the drain side can move
        if (w_out_fire) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_nxt      = ST_BUSY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase

    // Flush wins over the handshake: accepted input is dropped and main keeps
    // its last value so o_out_data only ever changes on a real load.
    if (i_flush) begin
      w_state_nxt      = ST_EMPTY;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
      r_main     <= RESET_VAL;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered ready: look ahead at the state being entered
      r_in_ready <= (w_state_nxt != ST_FULL);
      if (w_load_main) begin
        r_main <= w_main_from_skid ? r_skid : i_in_data;
      end
      if (w_load_skid) begin
        r_skid <= i_in_data;
      end
    end
  end

`ifdef PIPE_REG_HS_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !i_out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  // Counter absent; keep CNT_W referenced so the parameter list stays uniform.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
module tb_pipe_reg_hs;

  localparam logic       H  = 1'b1;
  localparam logic       L  = 1'b0;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
`ifdef PIPE_REG_HS_STATS_EN
  logic [3:0] stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_reg_hs #(
    .WIDTH    (8),
    .RESET_VAL(RV),
    .CNT_W    (4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_data (out_data)
`ifdef PIPE_REG_HS_STATS_EN
    ,
    .o_stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    logic [7:0] din;
    logic       ordy;
    logic       exp_ir;
    logic       exp_ov;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic f, input logic iv, input logic [7:0] d,
                     input logic o, input logic eir, input logic eov, input logic [7:0] ed);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.din = d; v.ordy = o;
    v.exp_ir = eir; v.exp_ov = eov; v.exp_d = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [7:0] d,
                       input logic o);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input int step, input logic eir, input logic eov,
                         input logic [7:0] ed);
    chk("in_ready", step, {31'd0, in_ready}, {31'd0, eir});
    chk("out_valid", step, {31'd0, out_valid}, {31'd0, eov});
    chk("out_data", step, {24'd0, out_data}, {24'd0, ed});
  endtask

  initial begin
    //   rst flush iv  din    ordy  ir  ov  data
    // reset two cycles, then stream 0x10..0x12
    add(H, L, L, 8'h00, L,  L, L, RV);
    add(H, L, L, 8'h00, L,  L, L, RV);
    add(L, L, H, 8'h10, H,  H, L, RV);     // in_ready rises, nothing accepted yet
    add(L, L, H, 8'h10, H,  H, H, 8'h10);
    add(L, L, H, 8'h11, H,  H, H, 8'h11);
    add(L, L, H, 8'h12, H,  H, H, 8'h12);
    add(L, L, L, 8'h00, H,  H, L, 8'h12);  // drained, data holds
    // backpressure 0xA,0xB,0xC
    add(L, L, H, 8'h0A, L,  H, H, 8'h0A);
    add(L, L, H, 8'h0B, L,  L, H, 8'h0A);  // 0xB into skid
    add(L, L, H, 8'h0C, L,  L, H, 8'h0A);  // 0xC refused
    add(L, L, H, 8'h0C, H,  H, H, 8'h0B);
    add(L, L, H, 8'h0C, H,  H, H, 8'h0C);
    add(L, L, L, 8'h00, H,  H, L, 8'h0C);
    // simultaneous fire in BUSY
    add(L, L, H, 8'h05, L,  H, H, 8'h05);
    add(L, L, H, 8'h06, H,  H, H, 8'h06);
    add(L, L, L, 8'h00, L,  H, H, 8'h06);  // still BUSY, skid untouched
    // flush while FULL with 0x77 offered
    add(L, L, H, 8'h07, L,  L, H, 8'h06);
    add(L, H, H, 8'h77, L,  H, L, 8'h06);
    add(L, L, L, 8'h00, H,  H, L, 8'h06);
    // flush with accepted input: dropped
    add(L, L, H, 8'h08, H,  H, H, 8'h08);
    add(L, H, H, 8'h09, H,  H, L, 8'h08);
    add(L, L, L, 8'h00, H,  H, L, 8'h08);
    // reset with both entries valid
    add(L, L, H, 8'h21, L,  H, H, 8'h21);
    add(L, L, H, 8'h22, L,  L, H, 8'h21);
    add(H, L, H, 8'h23, H,  L, L, RV);
    add(L, L, L, 8'h00, H,  H, L, RV);
    add(L, L, L, 8'h00, H,  H, L, RV);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].din, vecs[i].ordy);
      chk_out(i, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_d);
    end

    // full-rate stream: one new word every cycle
    for (int k = 0; k < 8; k++) begin
      drive(L, L, H, 8'h40 + 8'(k), H);
      chk_out(100 + k, H, H, 8'h40 + 8'(k));
    end
    drive(L, L, L, 8'h00, H);
    chk_out(108, H, L, 8'h47);

`ifdef PIPE_REG_HS_STATS_EN
    drive(L, L, H, 8'h30, L);
    chk_out(200, H, H, 8'h30);
    chk("stall_cnt", 200, {28'd0, stall_cnt}, 32'd0);
    for (int k = 0; k < 5; k++) drive(L, L, L, 8'h00, L);
    chk("stall_cnt", 201, {28'd0, stall_cnt}, 32'd5);
    for (int k = 0; k < 15; k++) drive(L, L, L, 8'h00, L);
    chk("stall_cnt", 202, {28'd0, stall_cnt}, 32'd15);
    drive(L, H, L, 8'h00, L);
    chk("stall_cnt", 203, {28'd0, stall_cnt}, 32'd15);
    chk_out(203, H, L, 8'h30);
    drive(H, L, L, 8'h00, L);
    chk("stall_cnt", 204, {28'd0, stall_cnt}, 32'd0);
    drive(L, L, L, 8'h00, L);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
